// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types for the GCD front-end bridge and the GCD engine.
//   bridge_state_t : bridge sequencing states
//   gcd_state_t    : engine states (load A, load B, subtract loop, result ack)
//   zero_bypass()  : true when an operand pair must be resolved without the engine
package gcd_pkg;

    localparam int unsigned DEFAULT_W  = 128;
    localparam int unsigned DEFAULT_CW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        REL_A  = 3'd2,
        LOAD_B = 3'd3,
        REL_B  = 3'd4,
        OUT    = 3'd5
    } bridge_state_t;

    typedef enum logic [2:0] {
        G_WAIT_A = 3'd0,
        G_REL_A  = 3'd1,
        G_WAIT_B = 3'd2,
        G_CMP    = 3'd3,
        G_SUB    = 3'd4,
        G_ACK    = 3'd5,
        G_DONE   = 3'd6
    } gcd_state_t;

    // The engine never terminates on a zero operand, so such pairs bypass it.
    function automatic logic zero_bypass(input logic a_is_zero, input logic b_is_zero);
        return a_is_zero | b_is_zero;
    endfunction

endpackage

// File: rtl/gcd_bridge_sat_counter.sv
// sat_counter: CW-bit up counter with synchronous clear and saturation at all-ones.
//   clock, reset : clock and asynchronous active-high reset
//   i_clear      : clear to zero (wins over enable)
//   i_en         : count enable
//   o_count      : current count
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] MAX_COUNT = '1;

    logic [CW-1:0] r_count;

    // Count register; holds at all-ones once reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_COUNT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gcd_bridge.sv
// gcd_bridge: valid/ready front end for the GCD engine. Accepts an operand pair,
// runs the two 4-phase req/ack loads (A then B), captures the engine result and
// presents it with a latency count. Zero operands are resolved locally.
//   clock, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready      : operand pair handshake, in_a / in_b operands
//   out_valid/out_ready    : result handshake, out_gcd result, out_cycles latency
//   err                    : sticky, engine acked while bridge idle or presenting
//   gcd_req/gcd_ack        : 4-phase handshake to the engine
//   gcd_load/gcd_result    : engine load value and engine result
module gcd_bridge
    import gcd_pkg::*;
#(
    parameter int unsigned W  = 128,
    parameter int unsigned CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_gcd,
    output logic [CW-1:0] out_cycles,
    output logic          err,
    output logic          gcd_req,
    input  logic          gcd_ack,
    output logic [W-1:0]  gcd_load,
    input  logic [W-1:0]  gcd_result
);

    localparam logic [CW-1:0] MAX_COUNT = '1;

    bridge_state_t r_state;
    bridge_state_t w_next;

    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_gcd;
    logic [CW-1:0] r_out_cycles;
    logic          r_err;
    logic          r_gcd_req;
    logic [W-1:0]  r_gcd_load;
    logic [W-1:0]  r_b;

    logic          w_xfer;
    logic          w_bypass;
    logic          w_cnt_en;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_inc;

    logic          w_in_ready_d;
    logic          w_out_valid_d;
    logic [W-1:0]  w_out_gcd_d;
    logic [CW-1:0] w_out_cycles_d;
    logic          w_err_d;
    logic          w_gcd_req_d;
    logic [W-1:0]  w_gcd_load_d;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_bypass  = zero_bypass(in_a == '0, in_b == '0);
    assign w_cnt_en  = (r_state != IDLE) && (r_state != OUT);
    // Latency includes the edge that enters OUT, hence count + 1 (saturating).
    assign w_cnt_inc = (w_cnt == MAX_COUNT) ? w_cnt : (w_cnt + CW'(1));

    sat_counter #(
        .CW (CW)
    ) u_sat_counter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_xfer),
        .i_en    (w_cnt_en),
        .o_count (w_cnt)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer)                   w_next = w_bypass ? OUT : LOAD_A;
            LOAD_A:  if (gcd_ack)                  w_next = REL_A;
            REL_A:   if (!gcd_ack)                 w_next = LOAD_B;
            LOAD_B:  if (gcd_ack)                  w_next = REL_B;
            // Waiting for ack low leaves the engine back in its A-wait state.
            REL_B:   if (!gcd_ack)                 w_next = OUT;
            OUT:     if (r_out_valid && out_ready) w_next = IDLE;
            default:                               w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the transition.
    always_comb begin
        w_in_ready_d   = (w_next == IDLE);
        w_out_valid_d  = (w_next == OUT);
        w_gcd_req_d    = (w_next == LOAD_A) || (w_next == LOAD_B);
        w_gcd_load_d   = r_gcd_load;
        w_out_gcd_d    = r_out_gcd;
        w_out_cycles_d = r_out_cycles;
        w_err_d        = r_err | (gcd_ack && ((r_state == IDLE) || (r_state == OUT)));

        if ((r_state == IDLE) && (w_next == LOAD_A)) begin
            w_gcd_load_d = in_a;
        end else if ((r_state == REL_A) && (w_next == LOAD_B)) begin
            w_gcd_load_d = r_b;
        end

        if ((r_state == IDLE) && (w_next == OUT)) begin
            w_out_gcd_d    = in_a | in_b;
            w_out_cycles_d = CW'(1);
        end else if ((r_state == LOAD_B) && (w_next == REL_B)) begin
            w_out_gcd_d    = gcd_result;
        end else if ((r_state == REL_B) && (w_next == OUT)) begin
            w_out_cycles_d = w_cnt_inc;
        end
    end

    // Output and operand registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_gcd    <= '0;
            r_out_cycles <= '0;
            r_err        <= 1'b0;
            r_gcd_req    <= 1'b0;
            r_gcd_load   <= '0;
            r_b          <= '0;
        end else begin
            r_in_ready   <= w_in_ready_d;
            r_out_valid  <= w_out_valid_d;
            r_out_gcd    <= w_out_gcd_d;
            r_out_cycles <= w_out_cycles_d;
            r_err        <= w_err_d;
            r_gcd_req    <= w_gcd_req_d;
            r_gcd_load   <= w_gcd_load_d;
            if (w_xfer) begin
                r_b <= in_b;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_gcd    = r_out_gcd;
    assign out_cycles = r_out_cycles;
    assign err        = r_err;
    assign gcd_req    = r_gcd_req;
    assign gcd_load   = r_gcd_load;

endmodule
